// File: rtl/conf_editor.sv
// conf_editor: front-panel sequencer for browsing, BCD-editing and committing config fields
module conf_editor #(
  parameter int DIGITS = 6,
  parameter int FIELDS = 5,
  parameter int GUARD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                btn_field,
  input  logic                btn_edit,
  input  logic                btn_cancel,
  input  logic                btn_digit,
  input  logic                btn_inc,
  input  logic                btn_dec,
  input  logic [DIGITS*4-1:0] selected_value,
  input  logic                ready,
  output logic [2:0]          selected_index,
  output logic [DIGITS*4-1:0] selected_new_value,
  output logic                selected_set,
  output logic [DIGITS*4-1:0] edit_value,
  output logic [2:0]          cursor,
  output logic                editing,
  output logic                busy
);
  localparam int GW = $clog2(GUARD + 2);
  typedef enum logic [1:0] {BROWSE, EDIT, COMMIT, WAIT_READY} state_t;
  state_t              r_state;
  logic [2:0]          r_field;
  logic [2:0]          r_cursor;
  logic [DIGITS*4-1:0] r_buf;
  logic [GW-1:0]       r_guard;
  logic [3:0]          w_nib;
  logic [3:0]          w_new;
  logic [DIGITS*4-1:0] w_buf;
  // Digit under the cursor stepped up or down with BCD wrap; non-BCD nibbles land on 0 (inc) or 9 (dec)
  always_comb begin
    w_nib = '0;
    for (int i = 0; i < DIGITS; i++) w_nib = (r_cursor == 3'(i)) ? r_buf[i*4 +: 4] : w_nib;
    w_new = btn_inc ? ((w_nib >= 4'd9) ? 4'd0 : w_nib + 4'd1)
                    : ((w_nib == 4'd0 || w_nib > 4'd9) ? 4'd9 : w_nib - 4'd1);
    w_buf = r_buf;
    for (int i = 0; i < DIGITS; i++) w_buf[i*4 +: 4] = (r_cursor == 3'(i)) ? w_new : r_buf[i*4 +: 4];
  end
  // Mode sequencing: browse fields, edit buffer, one-cycle commit strobe, guarded wait for ready
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= BROWSE;
      r_field  <= '0;
      r_cursor <= '0;
      r_buf    <= '0;
      r_guard  <= '0;
    end else if (ce) begin
      case (r_state)
        BROWSE:
          if (btn_edit) begin
            r_buf    <= selected_value;
            r_cursor <= '0;
            r_state  <= EDIT;
          end else if (btn_field) r_field <= (r_field == 3'(FIELDS - 1)) ? 3'd0 : r_field + 3'd1;
        EDIT:
          if (btn_cancel) r_state <= BROWSE;
          else if (btn_edit) r_state <= COMMIT;
          else if (btn_digit) r_cursor <= (r_cursor == 3'(DIGITS - 1)) ? 3'd0 : r_cursor + 3'd1;
          else if (btn_inc || btn_dec) r_buf <= w_buf;
        COMMIT: begin
          r_state <= WAIT_READY;
          r_guard <= GW'(GUARD);
        end
        default: begin
          if (r_guard != '0) r_guard <= r_guard - GW'(1);
          if (r_guard <= GW'(1) && ready) r_state <= BROWSE;
        end
      endcase
    end
  assign selected_index     = r_field;
  assign selected_new_value = r_buf;
  assign edit_value         = r_buf;
  assign cursor             = r_cursor;
  assign selected_set       = r_state == COMMIT;
  assign editing            = r_state == EDIT;
  assign busy               = r_state == COMMIT || r_state == WAIT_READY;
endmodule

// File: tb/tb_conf_editor.sv
// tb_conf_editor: directed plus randomized checks of conf_editor against a behavioural model
module tb_conf_editor;
  localparam int DIGITS = 6;
  localparam int FIELDS = 5;
  localparam int GUARD  = 2;
  logic clk = 0, rst = 0, ce = 0, ready = 0;
  logic btn_field = 0, btn_edit = 0, btn_cancel = 0, btn_digit = 0, btn_inc = 0, btn_dec = 0;
  logic [DIGITS*4-1:0] selected_value, selected_new_value, edit_value;
  logic [2:0] selected_index, cursor;
  logic selected_set, editing, busy;
  logic [DIGITS*4-1:0] bank [FIELDS];
  int checks = 0, errors = 0;
  int m_mode, m_field, m_cur, m_k;
  int md [DIGITS];
  conf_editor #(.DIGITS(DIGITS), .FIELDS(FIELDS), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .ce(ce), .btn_field(btn_field), .btn_edit(btn_edit),
    .btn_cancel(btn_cancel), .btn_digit(btn_digit), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .selected_value(selected_value), .ready(ready), .selected_index(selected_index),
    .selected_new_value(selected_new_value), .selected_set(selected_set),
    .edit_value(edit_value), .cursor(cursor), .editing(editing), .busy(busy)
  );
  always #5 clk = ~clk;
  always_comb selected_value = (selected_index < 3'(FIELDS)) ? bank[selected_index] : '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [31:0] mval();
    logic [31:0] v = 0;
    for (int i = 0; i < DIGITS; i++) v = v | (32'(md[i]) << (4 * i));
    return v;
  endfunction
  task automatic check_all(input string tag);
    check({tag, "_idx"}, 32'(selected_index), 32'(m_field));
    check({tag, "_set"}, 32'(selected_set), 32'(m_mode == 2 && m_k == 0));
    check({tag, "_nv"}, 32'(selected_new_value), mval());
    check({tag, "_ev"}, 32'(edit_value), mval());
    check({tag, "_cur"}, 32'(cursor), 32'(m_cur));
    check({tag, "_editing"}, 32'(editing), 32'(m_mode == 1));
    check({tag, "_busy"}, 32'(busy), 32'(m_mode == 2));
  endtask
  task automatic model_reset();
    m_mode = 0; m_field = 0; m_cur = 0; m_k = 0;
    for (int i = 0; i < DIGITS; i++) md[i] = 0;
  endtask
  task automatic do_reset(input string tag);
    rst = 1;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 0;
  endtask
  // b: {dec, inc, digit, cancel, edit, field}
  task automatic cyc(input string tag, input logic [5:0] b, input logic c, input logic r);
    {btn_dec, btn_inc, btn_digit, btn_cancel, btn_edit, btn_field} = b;
    ce = c; ready = r;
    @(posedge clk);
    if (c) begin
      if (m_mode == 0) begin
        if (b[1]) begin
          for (int i = 0; i < DIGITS; i++) md[i] = int'((bank[m_field] >> (4 * i)) & 24'hF);
          m_cur = 0; m_mode = 1;
        end else if (b[0]) m_field = (m_field + 1) % FIELDS;
      end else if (m_mode == 1) begin
        if (b[2]) m_mode = 0;
        else if (b[1]) begin m_mode = 2; m_k = 0; end
        else if (b[3]) m_cur = (m_cur + 1) % DIGITS;
        else if (b[4]) md[m_cur] = (md[m_cur] >= 9) ? 0 : md[m_cur] + 1;
        else if (b[5]) md[m_cur] = (md[m_cur] == 0 || md[m_cur] > 9) ? 9 : md[m_cur] - 1;
      end else begin
        if (m_k >= 1 && m_k >= GUARD && r) m_mode = 0;
        else m_k++;
      end
    end
    #1;
    check_all(tag);
    {btn_dec, btn_inc, btn_digit, btn_cancel, btn_edit, btn_field} = '0;
  endtask
  initial begin
    int bcnt;
    for (int i = 0; i < FIELDS; i++) bank[i] = '0;
    bank[0] = 24'h001000;
    bank[1] = 24'h000009;
    do_reset("reset");
    check("reset_idx_lit", 32'(selected_index), 0);
    for (int i = 0; i < 5; i++) cyc("t1_field", 6'b000001, 1, 0);
    check("t1_wrap_lit", 32'(selected_index), 0);
    cyc("t2_edit", 6'b000010, 1, 0);
    for (int i = 0; i < 3; i++) cyc("t2_digit", 6'b001000, 1, 0);
    for (int i = 0; i < 2; i++) cyc("t2_inc", 6'b010000, 1, 0);
    check("t2_val_lit", 32'(edit_value), 32'h003000);
    check("t2_cur_lit", 32'(cursor), 3);
    cyc("t2_commit", 6'b000010, 1, 0);
    check("t2_set_lit", 32'({selected_set, busy}), 32'b11);
    check("t2_nv_lit", 32'(selected_new_value), 32'h003000);
    for (int i = 0; i < 3; i++) cyc("t2_wait", 6'b000000, 1, 1);
    cyc("t3_field", 6'b000001, 1, 0);
    cyc("t3_edit", 6'b000010, 1, 0);
    cyc("t3_inc", 6'b010000, 1, 0);
    check("t3_wrap_lit", 32'(edit_value), 0);
    cyc("t3_dec", 6'b100000, 1, 0);
    check("t3_dec_lit", 32'(edit_value), 9);
    for (int i = 0; i < 5; i++) cyc("t3_digit", 6'b001000, 1, 0);
    check("t3_cur5_lit", 32'(cursor), 5);
    cyc("t3_digit_wrap", 6'b001000, 1, 0);
    check("t3_cur0_lit", 32'(cursor), 0);
    cyc("t4_inc", 6'b010000, 1, 0);
    cyc("t4_cancel", 6'b010110, 1, 0);
    check("t4_editing_lit", 32'({editing, selected_set}), 0);
    cyc("t5_edit", 6'b000010, 1, 0);
    cyc("t5_commit", 6'b000010, 1, 1);
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) bcnt++;
      cyc("t5_ready_hi", 6'b000000, 1, 1);
    end
    check("t5_busy_len", 32'(bcnt), 32'(1 + GUARD));
    cyc("t5_edit2", 6'b000010, 1, 0);
    cyc("t5_commit2", 6'b000010, 1, 0);
    for (int i = 0; i < 12; i++) cyc("t5_ready_lo", (i % 3 == 0) ? 6'b000010 : 6'b000000, 1, 0);
    check("t5_busy_hold_lit", 32'(busy), 1);
    cyc("t5_ready_rise", 6'b000000, 1, 1);
    check("t5_done_lit", 32'(busy), 0);
    for (int i = 0; i < 8; i++) cyc("t6_ce0", 6'($urandom_range(1, 63)), 0, 1);
    cyc("t6_edit", 6'b000010, 1, 0);
    cyc("t6_commit", 6'b000010, 1, 0);
    cyc("t6_wait", 6'b000000, 1, 0);
    do_reset("t6_rst");
    check("t6_rst_busy_lit", 32'(busy), 0);
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] b;
      b = 6'(1 << $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) b = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) b = '0;
      if ($urandom_range(0, 19) == 0) begin
        int f = $urandom_range(0, FIELDS - 1);
        bank[f] = 24'($urandom);
      end
      cyc("rand", b, $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) do_reset("rand_rst");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
